// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM encoding, the stall/flush bundle layout and its canned patterns.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TRAP     = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO            = 5'd0;
   localparam int         DEFAULT_MEM_TIMEOUT = 16;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_stall;
      logic id_ex_flush;
      logic ex_mem_stall;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } ctl_t;

   localparam ctl_t CTL_IDLE     = 8'b0000_0000;
   localparam ctl_t CTL_LOAD_USE = 8'b1100_1000;
   localparam ctl_t CTL_BRANCH   = 8'b0010_1000;
   localparam ctl_t CTL_MEM_STALL= 8'b1101_0101;
   localparam ctl_t CTL_TRAP     = 8'b0010_1010;
   localparam ctl_t CTL_ALLFLUSH = 8'b0010_1011;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the pipeline and stall/flush/debug outputs of the controller.
// master = pipeline side driving hazard info, slave = hazard controller.
interface pipeline_hazard_controller_if #(
   parameter int XLEN = 32
);
   logic [4:0]      ID_rs1;
   logic [4:0]      ID_rs2;
   logic            ID_uses_rs1;
   logic            ID_uses_rs2;
   logic            EX_memory_read;
   logic [4:0]      EX_rd;
   logic            EX_branch_taken;
   logic            MEM_memory_read;
   logic            MEM_memory_write;
   logic            dmem_ready;
   logic            trap_request;
   logic            trap_done;

   logic            pc_stall;
   logic            IF_ID_stall;
   logic            IF_ID_flush;
   logic            ID_EX_stall;
   logic            ID_EX_flush;
   logic            EX_MEM_stall;
   logic            EX_MEM_flush;
   logic            MEM_WB_flush;
   logic            bus_error;
   logic [XLEN-1:0] stall_count;
   logic [XLEN-1:0] flush_count;

   modport master (
      output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_memory_read, EX_rd,
             EX_branch_taken, MEM_memory_read, MEM_memory_write, dmem_ready,
             trap_request, trap_done,
      input  pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
             EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, bus_error,
             stall_count, flush_count
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_memory_read, EX_rd,
             EX_branch_taken, MEM_memory_read, MEM_memory_write, dmem_ready,
             trap_request, trap_done,
      output pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
             EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, bus_error,
             stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter for performance debug; sticks at all-ones.
// Value updates one cycle after inc; no backpressure.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);
   logic [WIDTH-1:0] r_value;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_value <= '0;
      end else if (inc && (r_value != '1)) begin
         r_value <= r_value + 1'b1;
      end
   end

   assign value = r_value;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, dmem wait/timeout, trap drain.
// Stall/flush are same-cycle combinational; bus_error and counters are registered.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
   input logic                         clk,
   input logic                         reset,
   pipeline_hazard_controller_if.slave bus
);
   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_cnt_nxt;
   logic       r_bus_error;
   logic       w_timeout;
   logic       w_mem_busy;
   logic       w_load_use;
   ctl_t       w_ctl;

   assign w_mem_busy = (bus.MEM_memory_read | bus.MEM_memory_write) & ~bus.dmem_ready;
   assign w_load_use = bus.EX_memory_read & (bus.EX_rd != REG_ZERO) &
                       ((bus.ID_uses_rs1 & (bus.ID_rs1 == bus.EX_rd)) |
                        (bus.ID_uses_rs2 & (bus.ID_rs2 == bus.EX_rd)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         r_bus_error <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_bus_error <= w_timeout;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_timeout      = 1'b0;
      w_ctl          = CTL_IDLE;
      case (r_state)
         RUN: begin
            if (bus.trap_request) begin
               w_ctl       = CTL_TRAP;
               w_state_nxt = TRAP;
            end else if (w_mem_busy) begin
               w_ctl          = CTL_MEM_STALL;
               w_wait_cnt_nxt = 8'd1;
               w_state_nxt    = MEM_WAIT;
            end else if (bus.EX_branch_taken) begin
               w_ctl = CTL_BRANCH;
            end else if (w_load_use) begin
               w_ctl = CTL_LOAD_USE;
            end
         end
         MEM_WAIT: begin
            if (w_mem_busy) begin
               if (r_wait_cnt == TIMEOUT_CNT) begin
                  w_ctl          = CTL_ALLFLUSH;
                  w_timeout      = 1'b1;
                  w_wait_cnt_nxt = '0;
                  w_state_nxt    = TRAP;
               end else begin
                  w_ctl          = CTL_MEM_STALL;
                  w_wait_cnt_nxt = r_wait_cnt + 8'd1;
               end
            end else begin
               // Release cycle: EX/ID were frozen, so their hazards are resolved now.
               w_wait_cnt_nxt = '0;
               w_state_nxt    = RUN;
               if (bus.EX_branch_taken) begin
                  w_ctl = CTL_BRANCH;
               end else if (w_load_use) begin
                  w_ctl = CTL_LOAD_USE;
               end
            end
         end
         TRAP: begin
            w_ctl = CTL_TRAP;
            if (bus.trap_done) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
      if (!reset) begin
         w_ctl = CTL_ALLFLUSH;
      end
   end

   assign bus.pc_stall     = w_ctl.pc_stall;
   assign bus.IF_ID_stall  = w_ctl.if_id_stall;
   assign bus.IF_ID_flush  = w_ctl.if_id_flush;
   assign bus.ID_EX_stall  = w_ctl.id_ex_stall;
   assign bus.ID_EX_flush  = w_ctl.id_ex_flush;
   assign bus.EX_MEM_stall = w_ctl.ex_mem_stall;
   assign bus.EX_MEM_flush = w_ctl.ex_mem_flush;
   assign bus.MEM_WB_flush = w_ctl.mem_wb_flush;
   assign bus.bus_error    = r_bus_error;

   sat_counter #(.WIDTH(XLEN)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_ctl.pc_stall),
      .value (bus.stall_count)
   );

   sat_counter #(.WIDTH(XLEN)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_ctl.if_id_flush),
      .value (bus.flush_count)
   );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MEM_TIMEOUT=4) plus a 2-bit sat_counter.
module tb_pipeline_hazard_controller;
   logic clk;
   logic reset;
   logic sat_reset;
   logic sat_inc;
   logic [1:0] sat_val;
   logic [7:0] ctl;
   int n_assert;
   int n_fail;

   localparam logic [7:0] IDLE     = 8'b0000_0000;
   localparam logic [7:0] LOADUSE  = 8'b1100_1000;
   localparam logic [7:0] BRANCH   = 8'b0010_1000;
   localparam logic [7:0] MEMSTALL = 8'b1101_0101;
   localparam logic [7:0] TRAPF    = 8'b0010_1010;
   localparam logic [7:0] ALLFLUSH = 8'b0010_1011;

   pipeline_hazard_controller_if #(.XLEN(32)) bus ();

   pipeline_hazard_controller #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   sat_counter #(.WIDTH(2)) u_sat (
      .clk   (clk),
      .reset (sat_reset),
      .inc   (sat_inc),
      .value (sat_val)
   );

   assign ctl = {bus.pc_stall, bus.IF_ID_stall, bus.IF_ID_flush, bus.ID_EX_stall,
                 bus.ID_EX_flush, bus.EX_MEM_stall, bus.EX_MEM_flush, bus.MEM_WB_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ID_rs1 = 5'd0;           bus.ID_rs2 = 5'd0;
      bus.ID_uses_rs1 = 1'b0;      bus.ID_uses_rs2 = 1'b0;
      bus.EX_memory_read = 1'b0;   bus.EX_rd = 5'd0;
      bus.EX_branch_taken = 1'b0;  bus.MEM_memory_read = 1'b0;
      bus.MEM_memory_write = 1'b0; bus.dmem_ready = 1'b0;
      bus.trap_request = 1'b0;     bus.trap_done = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail = 0;
      reset = 1'b0;
      sat_reset = 1'b0;
      sat_inc = 1'b0;
      idle();
      tick(); tick();
      #1;
      chk("reset_ctl", ctl, ALLFLUSH);
      chk("reset_stall_cnt", bus.stall_count, 0);
      chk("reset_flush_cnt", bus.flush_count, 0);
      chk("reset_bus_err", bus.bus_error, 0);
      reset = 1'b1;
      #1;
      chk("run_idle", ctl, IDLE);

      // Load-use on rs1, then on rs2
      bus.EX_memory_read = 1'b1; bus.EX_rd = 5'd5; bus.ID_rs1 = 5'd5; bus.ID_uses_rs1 = 1'b1;
      #1 chk("lu_rs1", ctl, LOADUSE);
      tick();
      chk("lu_stall_cnt", bus.stall_count, 1);
      bus.EX_memory_read = 1'b0;
      #1 chk("lu_single_bubble", ctl, IDLE);
      bus.EX_memory_read = 1'b1; bus.EX_rd = 5'd0; bus.ID_rs1 = 5'd0;
      #1 chk("lu_x0", ctl, IDLE);
      bus.EX_rd = 5'd7; bus.ID_rs2 = 5'd7; bus.ID_uses_rs1 = 1'b0; bus.ID_uses_rs2 = 1'b1;
      #1 chk("lu_rs2", ctl, LOADUSE);
      tick();
      chk("lu_rs2_cnt", bus.stall_count, 2);
      bus.ID_uses_rs2 = 1'b0;
      #1 chk("lu_not_used", ctl, IDLE);

      // Branch beats load-use
      bus.EX_rd = 5'd5; bus.ID_rs1 = 5'd5; bus.ID_uses_rs1 = 1'b1; bus.EX_branch_taken = 1'b1;
      #1 chk("br_over_lu", ctl, BRANCH);
      tick();
      chk("br_flush_cnt", bus.flush_count, 1);
      chk("br_stall_cnt", bus.stall_count, 2);
      idle();

      // Three-cycle store wait; a branch during the wait is deferred to release
      bus.MEM_memory_write = 1'b1;
      #1 chk("mw_c0", ctl, MEMSTALL);
      tick();
      bus.EX_branch_taken = 1'b1;
      #1 chk("mw_c1_br_ignored", ctl, MEMSTALL);
      tick();
      #1 chk("mw_c2", ctl, MEMSTALL);
      tick();
      bus.dmem_ready = 1'b1;
      #1 chk("mw_release_br", ctl, BRANCH);
      tick();
      chk("mw_stall_cnt", bus.stall_count, 5);
      chk("mw_flush_cnt", bus.flush_count, 2);
      idle();
      #1 chk("mw_back_run", ctl, IDLE);
      bus.MEM_memory_read = 1'b1; bus.dmem_ready = 1'b1;
      #1 chk("zero_wait", ctl, IDLE);
      tick();
      chk("zero_wait_cnt", bus.stall_count, 5);
      idle();

      // Timeout: 4 stall cycles, then all-flush, bus_error next cycle, TRAP
      bus.MEM_memory_read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("to_stall", ctl, MEMSTALL);
         tick();
      end
      chk("to_stall_cnt", bus.stall_count, 9);
      #1 chk("to_flush", ctl, ALLFLUSH);
      chk("to_no_err_yet", bus.bus_error, 0);
      tick();
      chk("to_bus_err", bus.bus_error, 1);
      chk("to_flush_cnt", bus.flush_count, 3);
      bus.MEM_memory_read = 1'b0;
      #1 chk("to_trap", ctl, TRAPF);
      tick();
      chk("to_err_pulse", bus.bus_error, 0);
      bus.trap_done = 1'b1;
      #1 chk("to_trap_done", ctl, TRAPF);
      tick();
      bus.trap_done = 1'b0;
      #1 chk("to_run", ctl, IDLE);
      chk("to_flush_cnt2", bus.flush_count, 5);

      // Trap beats mem_busy; second trap_request in TRAP ignored
      bus.trap_request = 1'b1; bus.MEM_memory_write = 1'b1;
      #1 chk("tr_enter", ctl, TRAPF);
      tick();
      bus.MEM_memory_write = 1'b0;
      #1 chk("tr_hold1", ctl, TRAPF);
      tick();
      bus.trap_request = 1'b0;
      #1 chk("tr_hold2", ctl, TRAPF);
      tick();
      bus.trap_done = 1'b1;
      #1 chk("tr_done", ctl, TRAPF);
      tick();
      bus.trap_done = 1'b0;
      #1 chk("tr_run", ctl, IDLE);
      chk("tr_flush_cnt", bus.flush_count, 9);
      chk("tr_stall_cnt", bus.stall_count, 9);

      // Reset during MEM_WAIT at wait_cnt=2
      bus.MEM_memory_write = 1'b1;
      tick(); tick();
      #1 chk("rst_pre", ctl, MEMSTALL);
      chk("rst_pre_cnt", bus.stall_count, 11);
      reset = 1'b0;
      #1 chk("rst_ctl", ctl, ALLFLUSH);
      chk("rst_stall_cnt", bus.stall_count, 0);
      chk("rst_flush_cnt", bus.flush_count, 0);
      tick();
      chk("rst_held_flush_cnt", bus.flush_count, 0);
      idle();
      reset = 1'b1;
      #1 chk("rst_run", ctl, IDLE);
      tick();
      chk("rst_run_cnt", bus.stall_count, 0);
      bus.MEM_memory_write = 1'b1;
      #1 chk("rst_new_wait", ctl, MEMSTALL);
      tick();
      bus.dmem_ready = 1'b1;
      #1 chk("rst_new_release", ctl, IDLE);
      tick();
      chk("rst_new_cnt", bus.stall_count, 1);
      idle();

      // Saturation on a 2-bit counter
      sat_reset = 1'b1;
      sat_inc = 1'b1;
      tick(); tick();
      chk("sat_two", sat_val, 2);
      tick(); tick(); tick();
      chk("sat_hold", sat_val, 3);
      sat_inc = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
